// File: rtl/bram_pkg.sv
// Shared constants and FSM state type for the BRAM stream reader.
// The optional abort feature is enabled with the BRAM_READER_ABORT_EN macro.
package bram_pkg;

    localparam int BRAM_READ_LATENCY     = 1;
    localparam int BRAM_READER_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } bram_reader_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that catches BRAM read data and carries a last-word flag
// alongside each entry.
module skid_fifo2
    import bram_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [data_width-1:0] head_data_o,
    output logic                  head_last_o
);

    logic [data_width-1:0] data_q [BRAM_READER_BUF_DEPTH];
    logic                  last_q [BRAM_READER_BUF_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BRAM_READER_BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign count_o     = count_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_last_o = last_q[rd_ptr_q];

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a range of BRAM words out over valid/ready, hiding the read latency.
// Define BRAM_READER_ABORT_EN to add the abort input.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [addr_width:0]   cmd_len,
    output logic [addr_width-1:0] raddr,
    input  logic [data_width-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_last,
    output logic                  done
`ifdef BRAM_READER_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    bram_reader_state_t    state_q;
    logic [addr_width-1:0] addr_q;
    logic [addr_width:0]   issue_left_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic [1:0]            fifo_count;
    logic                  head_last;
    logic                  pop;
    logic                  issue;
    logic                  abort_hit;
    logic [2:0]            occupancy_d;

`ifdef BRAM_READER_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && head_last;
    assign cmd_ready = (state_q == IDLE);
    assign raddr     = addr_q;
    assign done      = done_q;

    // Slots still claimed after this edge: a read may only go out if its data has a home.
    assign occupancy_d = {1'b0, fifo_count} + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == READ) && (issue_left_q != '0)
                && (occupancy_d < 3'(BRAM_READER_BUF_DEPTH));

    skid_fifo2 #(
        .data_width(data_width)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (abort_hit),
        .push_i     (inflight_q),
        .push_data_i(rdata),
        .push_last_i(inflight_last_q),
        .pop_i      (pop),
        .count_o    (fifo_count),
        .head_data_o(out_data),
        .head_last_o(head_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issue_left_q == (addr_width + 1)'(1));
            if (abort_hit) begin
                state_q      <= IDLE;
                issue_left_q <= '0;
                inflight_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid) begin
                            if (cmd_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                addr_q       <= cmd_addr;
                                issue_left_q <= cmd_len;
                                state_q      <= READ;
                            end
                        end
                    end
                    READ: begin
                        if (issue) begin
                            addr_q       <= addr_q + addr_width'(1);
                            issue_left_q <= issue_left_q - (addr_width + 1)'(1);
                            if (issue_left_q == (addr_width + 1)'(1)) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop && head_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
